nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_add_ctrl_cla.sv | 29 ++
 rtl/nibble_serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_cla.sv
// 4-bit carry-lookahead adder slice: all internal carries come from generate/propagate terms.
module CLA_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract built from one 4-bit CLA slice, stepped one nibble per cycle LSB first.
import nibble_serial_add_ctrl_pkg::*;

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);

  localparam int NIB  = WIDTH / NIBBLE;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovfl;
  logic              r_sign_a;
  logic              r_sign_b;

  logic              w_accept;
  logic              w_last;
  logic [NIB-1:0]    w_sel;
  logic [NIBBLE-1:0] w_a_nib;
  logic [NIBBLE-1:0] w_b_nib;
  logic [NIBBLE-1:0] w_slice_sum;
  logic              w_slice_cout;

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_DONE);
  assign w_accept   = req_valid && req_ready;
  assign w_last     = (r_state == ST_RUN) && (r_idx == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_sel
      assign w_sel[gi] = (r_idx == IDXW'(gi));
    end
  endgenerate

  // One-hot nibble mux feeding the shared slice.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (w_sel[i]) begin
        w_a_nib = r_a[i*NIBBLE +: NIBBLE];
        w_b_nib = r_b[i*NIBBLE +: NIBBLE];
      end
    end
  end

  CLA_4bit u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: if (resp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovfl   <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
      r_a      <= a;
      r_b      <= sub ? ~b : b;
      r_carry  <= sub;
      r_idx    <= '0;
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (w_sel[i]) r_sum[i*NIBBLE +: NIBBLE] <= w_slice_sum;
      end
      r_carry <= w_slice_cout;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_slice_cout;
        r_ovfl <= (r_sign_a == r_sign_b) && (w_slice_sum[NIBBLE-1] != r_sign_a);
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovfl = r_ovfl;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed scoreboard bench: stimulus pushes expected results, a monitor pops on each response handshake.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .sum        (sum),
    .cout       (cout),
    .ovfl       (ovfl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on resp_valid rise, result fields on handshake, ready the cycle after.
  logic prev_valid = 1'b0;
  bit   chk_after  = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      chk_after  = 1'b0;
    end else begin
      if (chk_after) begin
        check("req_ready_after_resp", 32'(req_ready), 32'd1);
        check("resp_valid_after_resp", 32'(resp_valid), 32'd0);
        chk_after = 1'b0;
      end
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_resp: got sum 0x%0h with empty scoreboard", sum);
        end else begin
          check("latency", 32'(cyc - sb[0].acc), 32'(NIB));
        end
      end
      if (resp_valid && resp_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] resp sum=0x%04h cout=%0b ovfl=%0b (exp 0x%04h %0b %0b)",
                 sum, cout, ovfl, e.sum, e.cout, e.ovfl);
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovfl", 32'(ovfl), 32'(e.ovfl));
        chk_after = 1'b1;
      end
      prev_valid = resp_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with req_valid dropped.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo, input bit push);
    int waited = 0;
    exp_t e;
    a = ta;
    b = tb_;
    sub = ts;
    req_valid = 1'b1;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: req_ready stayed 0 for %0d cycles", waited);
    end else begin
      $display("[TB] req a=0x%04h b=0x%04h sub=%0b", ta, tb_, ts);
      if (push) begin
        e.sum = es; e.cout = ec; e.ovfl = eo; e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovfl", 32'(ovfl), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure with a second request held pending.
    resp_ready = 1'b0;
    send(16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    waited = 0;
    while (!resp_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    a = 16'h9000;
    b = 16'h2000;
    sub = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h0FFF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    send(16'h9000, 16'h2000, 1'b1, 16'h7000, 1'b1, 1'b1, 1'b1);
    drain();

    // Abort in the second RUN cycle; no response may appear for it.
    send(16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
